// File: rtl/shift_ring_if.sv
// Bundles the control, data and status signals of shift_ring.
// Clock and reset stay as plain ports on the module.
interface shift_ring_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  logic                   en_i;
  logic [1:0]             mode_i;
  logic                   dir_i;
  logic [WIDTH-1:0]       data_i;
  logic [DEPTH*WIDTH-1:0] load_i;
  logic                   start_i;
  logic [CNT_W-1:0]       burst_len_i;
  logic [WIDTH-1:0]       data_o;
  logic [DEPTH*WIDTH-1:0] par_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output en_i, mode_i, dir_i, data_i, load_i, start_i, burst_len_i,
    input  data_o, par_o, busy_o, done_o
  );

  modport slave (
    input  en_i, mode_i, dir_i, data_i, load_i, start_i, burst_len_i,
    output data_o, par_o, busy_o, done_o
  );
endinterface

// File: rtl/shift_ring.sv
// Multi-stage shift/rotate register with single-step operations and
// counted bursts that latch their mode and direction.
module shift_ring #(
  parameter int                         WIDTH     = 1,
  parameter int                         DEPTH     = 8,
  parameter logic [DEPTH*WIDTH-1:0]     RESET_VAL = 8'b10101010,
  parameter int                         CNT_W     = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  shift_ring_if.slave  bus
);

  typedef enum logic [1:0] {M_HOLD, M_SHIFT, M_ROT, M_LOAD} mode_e;
  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH*WIDTH-1:0] par_q, par_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   rot_q, rot_d;
  logic                   done_q, done_d;
  mode_e                  mode_in;
  logic                   dsel;

  // Entry stage is 0 for dir 0 and DEPTH-1 for dir 1; it gets data_i or the exiting stage.
  function automatic logic [DEPTH*WIDTH-1:0] step_f(
    input logic [DEPTH*WIDTH-1:0] cur,
    input logic                   rot,
    input logic                   dir,
    input logic [WIDTH-1:0]       din
  );
    logic [WIDTH-1:0] entry;
    if (!dir) begin
      entry = rot ? cur[DEPTH*WIDTH-1 -: WIDTH] : din;
      return {cur[(DEPTH-1)*WIDTH-1:0], entry};
    end else begin
      entry = rot ? cur[WIDTH-1:0] : din;
      return {entry, cur[DEPTH*WIDTH-1:WIDTH]};
    end
  endfunction

  assign mode_in = mode_e'(bus.mode_i);

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if ((bus.burst_len_i != '0) && ((mode_in == M_SHIFT) || (mode_in == M_ROT))) begin
            state_d = S_BUSY;
            cnt_d   = bus.burst_len_i;
            dir_d   = bus.dir_i;
            rot_d   = (mode_in == M_ROT);
          end
        end else if (bus.en_i) begin
          case (mode_in)
            M_SHIFT: par_d = step_f(par_q, 1'b0, bus.dir_i, bus.data_i);
            M_ROT:   par_d = step_f(par_q, 1'b1, bus.dir_i, bus.data_i);
            M_LOAD:  par_d = bus.load_i;
            default: par_d = par_q;
          endcase
        end
      end
      S_BUSY: begin
        par_d = step_f(par_q, rot_q, dir_q, bus.data_i);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      par_q   <= RESET_VAL;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  // Serial output follows the live dir_i when idle, the latched direction during a burst.
  assign dsel       = (state_q == S_BUSY) ? dir_q : bus.dir_i;
  assign bus.data_o = dsel ? par_q[WIDTH-1:0] : par_q[DEPTH*WIDTH-1 -: WIDTH];
  assign bus.par_o  = par_q;
  assign bus.busy_o = (state_q == S_BUSY);
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_shift_ring.sv
// Scoreboarded bench for shift_ring: a queue-based stage model predicts every
// cycle's outputs, and a monitor compares them after each rising edge.
module tb_shift_ring;
  localparam int W = 1;
  localparam int D = 8;
  localparam int C = 8;
  localparam logic [7:0] RV = 8'hAA;

  typedef struct {
    logic [7:0] par;
    logic       busy;
    logic       done;
    logic       dout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  shift_ring_if #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) bus ();

  shift_ring #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV), .CNT_W(C)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: stages held in a queue, index 0 = stage 0.
  logic [W-1:0] mq[$];
  bit           m_busy;
  int           m_cnt;
  bit           m_rot;
  bit           m_dir;
  bit           m_done;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_apply(input bit rot, input bit dir, input logic [W-1:0] d);
    logic [W-1:0] t;
    if (!dir) begin
      t = mq.pop_back();
      mq.push_front(rot ? t : d);
    end else begin
      t = mq.pop_front();
      mq.push_back(rot ? t : d);
    end
  endtask

  // Advance the model by one clock using the inputs just driven, queue the result.
  task automatic model_step();
    exp_t e;
    bit   dsel;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < D; i++) mq.push_back(RV[i]);
      m_busy = 0; m_cnt = 0; m_dir = 0; m_rot = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_apply(m_rot, m_dir, bus.data_i);
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (bus.start_i) begin
        if (bus.burst_len_i != 0 && (bus.mode_i == 2'd1 || bus.mode_i == 2'd2)) begin
          m_busy = 1;
          m_cnt  = int'(bus.burst_len_i);
          m_rot  = (bus.mode_i == 2'd2);
          m_dir  = bus.dir_i;
        end
      end else if (bus.en_i) begin
        case (bus.mode_i)
          2'd1: m_apply(0, bus.dir_i, bus.data_i);
          2'd2: m_apply(1, bus.dir_i, bus.data_i);
          2'd3: begin
            mq.delete();
            for (int i = 0; i < D; i++) mq.push_back(bus.load_i[i]);
          end
          default: ;
        endcase
      end
    end
    for (int i = 0; i < D; i++) e.par[i] = mq[i][0];
    e.busy = m_busy;
    e.done = m_done;
    dsel   = m_busy ? m_dir : bus.dir_i;
    e.dout = dsel ? mq[0][0] : mq[D-1][0];
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic dr,
                       input logic dd, input logic [7:0] ld, input logic st, input logic [7:0] ln);
    @(negedge clk);
    rst             = r;
    bus.en_i        = e;
    bus.mode_i      = m;
    bus.dir_i       = dr;
    bus.data_i      = dd;
    bus.load_i      = ld;
    bus.start_i     = st;
    bus.burst_len_i = ln;
    model_step();
  endtask

  task automatic idle();
    drive(0, 0, 2'd0, 0, 0, 8'h00, 0, 8'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("sb_par",  64'(bus.par_o),  64'(e.par));
      cmp("sb_busy", 64'(bus.busy_o), 64'(e.busy));
      cmp("sb_done", 64'(bus.done_o), 64'(e.done));
      cmp("sb_dout", 64'(bus.data_o), 64'(e.dout));
    end
  end

  initial begin
    bus.en_i = 0; bus.mode_i = 0; bus.dir_i = 0; bus.data_i = 0;
    bus.load_i = 0; bus.start_i = 0; bus.burst_len_i = 0;

    // Reset state
    repeat (3) drive(1, 0, 2'd0, 0, 0, 8'h00, 0, 8'd0);
    settle();
    cmp("rst_par",  64'(bus.par_o), 64'h AA);
    cmp("rst_busy", 64'(bus.busy_o), 64'd0);
    cmp("rst_done", 64'(bus.done_o), 64'd0);
    cmp("rst_dout", 64'(bus.data_o), 64'd1);

    // Single-step rotates
    drive(0, 1, 2'd2, 0, 0, 8'h00, 0, 8'd0);
    settle();
    cmp("rot1", 64'(bus.par_o), 64'h55);
    for (int i = 0; i < 7; i++) drive(0, 1, 2'd2, 0, 0, 8'h00, 0, 8'd0);
    settle();
    cmp("rot8", 64'(bus.par_o), 64'hAA);

    // Load then serial shift
    drive(0, 1, 2'd3, 0, 0, 8'hC3, 0, 8'd0);
    settle();
    cmp("load",      64'(bus.par_o), 64'hC3);
    cmp("dout_pre",  64'(bus.data_o), 64'd1);
    drive(0, 1, 2'd1, 0, 1, 8'h00, 0, 8'd0);
    settle();
    cmp("shift", 64'(bus.par_o), 64'h87);

    // Burst rotate down; mode/dir changes and start during burst ignored
    drive(0, 1, 2'd3, 0, 0, 8'h01, 0, 8'd0);
    drive(0, 1, 2'd2, 1, 0, 8'h00, 1, 8'd3);
    settle();
    cmp("b_busy0", 64'(bus.busy_o), 64'd1);
    drive(0, 1, 2'd1, 0, 1, 8'hFF, 1, 8'd7);
    settle();
    cmp("b_step1", 64'(bus.par_o), 64'h80);
    drive(0, 0, 2'd3, 0, 1, 8'hFF, 0, 8'd0);
    settle();
    cmp("b_step2", 64'(bus.par_o), 64'h40);
    idle();
    settle();
    cmp("b_step3", 64'(bus.par_o), 64'h20);
    cmp("b_done",  64'(bus.done_o), 64'd1);
    cmp("b_idle",  64'(bus.busy_o), 64'd0);
    idle();
    settle();
    cmp("b_done_gone", 64'(bus.done_o), 64'd0);

    // Reset mid-burst
    drive(0, 0, 2'd2, 0, 0, 8'h00, 1, 8'd5);
    idle();
    drive(1, 0, 2'd0, 0, 0, 8'h00, 0, 8'd0);
    settle();
    cmp("abort_par",  64'(bus.par_o), 64'hAA);
    cmp("abort_busy", 64'(bus.busy_o), 64'd0);
    idle();
    settle();
    cmp("abort_nodone", 64'(bus.done_o), 64'd0);

    // Ignored starts, then back-to-back in the done cycle
    drive(0, 1, 2'd2, 0, 0, 8'h00, 1, 8'd0);
    settle();
    cmp("len0_ign", 64'(bus.busy_o), 64'd0);
    cmp("len0_en_ign", 64'(bus.par_o), 64'hAA);
    drive(0, 0, 2'd3, 0, 0, 8'hFF, 1, 8'd4);
    settle();
    cmp("mode3_ign", 64'(bus.par_o), 64'hAA);
    drive(0, 0, 2'd1, 0, 1, 8'h00, 1, 8'd1);
    settle();
    cmp("n1_busy", 64'(bus.busy_o), 64'd1);
    drive(0, 0, 2'd2, 1, 0, 8'h00, 1, 8'd2);
    settle();
    cmp("n1_done", 64'(bus.done_o), 64'd1);
    drive(0, 0, 2'd2, 1, 0, 8'h00, 1, 8'd2);
    settle();
    cmp("b2b_busy", 64'(bus.busy_o), 64'd1);
    idle();
    idle();

    // Maximum-length burst
    drive(0, 0, 2'd2, 0, 0, 8'h00, 1, 8'd255);
    for (int i = 0; i < 255; i++) begin
      idle();
      settle();
      cmp("long_busy", 64'(bus.busy_o), (i < 254) ? 64'd1 : 64'd0);
    end
    idle();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 100) == 0, $urandom % 2, 2'($urandom % 4), $urandom % 2,
            $urandom % 2, 8'($urandom), ($urandom % 6) == 0,
            (($urandom % 4) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
    end

    @(posedge clk);
    #2;
    cmp("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_ring.md
SHIFT_RING -- requirements
Module: shift_ring

Interface
REQ-001 Parameter WIDTH, default 1: bits per stage (>=1).
REQ-002 Parameter DEPTH, default 8: number of stages (>=2).
REQ-003 Parameter RESET_VAL, default 8'b10101010 (stage i = i%2), DEPTH*WIDTH bits: stage i reset value at bits [i*WIDTH +: WIDTH].
REQ-004 Parameter CNT_W, default 8: width of burst length and counter.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 reset_i  in  1  synchronous active-high reset.
REQ-008 en_i  in  1  perform one single step of mode_i/dir_i this cycle (idle only).
REQ-009 mode_i  in  2  00 hold, 01 serial shift, 10 rotate, 11 parallel load.
REQ-010 dir_i  in  1  0: stage i <= stage i-1 (up); 1: stage i <= stage i+1 (down).
REQ-011 data_i  in  WIDTH  serial input, enters stage 0 (dir 0) or stage DEPTH-1 (dir 1).
REQ-012 load_i  in  DEPTH*WIDTH  parallel load value.
REQ-013 start_i  in  1  start burst of burst_len_i steps.
REQ-014 burst_len_i  in  CNT_W  burst step count.
REQ-015 data_o  out  WIDTH  serial out: stage DEPTH-1 (dir 0) or stage 0 (dir 1), combinational from current dir (latched dir during burst).
REQ-016 par_o  out  DEPTH*WIDTH  all stages, registered.
REQ-017 busy_o  out  1  burst in progress.
REQ-018 done_o  out  1  one-cycle pulse after final burst step.

Function
REQ-019 Serial shift SHALL move every stage one position in dir and insert data_i at the entry stage; exiting stage discarded.
REQ-020 Rotate SHALL move every stage one position in dir, exiting stage wraps into entry stage; data_i ignored.
REQ-021 Load SHALL set par_o <= load_i in one cycle; hold SHALL leave state unchanged.
REQ-022 Single step: en_i=1 while busy_o=0 and start_i=0 SHALL apply the operation; result visible on par_o next cycle (latency 1).
REQ-023 Idle state: start_i=1 with burst_len_i=N>0 and mode_i in {01,10} SHALL latch mode, dir, counter=N and enter BUSY; busy_o=1 from next cycle.
REQ-024 start_i with burst_len_i=0 or mode_i in {00,11} SHALL be ignored: no state change, no busy, no done.
REQ-025 start_i and en_i together while idle: start_i SHALL win, en_i ignored.
REQ-026 BUSY: each cycle one step of latched mode/dir, counter decrements; serial shift samples data_i every busy cycle.
REQ-027 After the step with counter=1, SHALL return to IDLE: busy_o=0 and done_o=1 for exactly that following cycle; N steps occupy exactly N busy cycles.
REQ-028 start_i and en_i while busy_o=1 SHALL be ignored; mode_i/dir_i changes during burst SHALL have no effect.
REQ-029 A new start_i in the done_o cycle SHALL be accepted (back-to-back bursts).
REQ-030 Burst of N=2^CNT_W-1 SHALL complete without counter wrap.

Reset
REQ-031 reset_i=1 SHALL set par_o=RESET_VAL, busy_o=0, done_o=0, counter=0, latched dir=0; data_o follows from these.
REQ-032 reset_i SHALL override all inputs; reset mid-burst aborts burst with no done_o pulse.

Verification (DEPTH=8, WIDTH=1, defaults)
REQ-033 Reset 3 cycles -> par_o=8'hAA, busy_o=0, done_o=0, data_o=1.
REQ-034 From 8'hAA, en_i=1 rotate dir 0 one cycle -> 8'h55; 8 total rotates -> 8'hAA.
REQ-035 Load 8'hC3, then en_i serial shift dir 0 data_i=1 -> 8'h87; data_o before shift=1.
REQ-036 Load 8'h01, start_i rotate dir 1 burst_len_i=3 -> par_o 8'h80, 8'h40, 8'h20 on 3 busy cycles; done_o=1 next cycle only.
REQ-037 Start burst_len_i=5, assert reset_i on 2nd busy cycle -> next cycle par_o=8'hAA, busy_o=0, no done_o.
REQ-038 start_i during busy, burst_len_i=0, and mode 11 start -> all ignored; back-to-back start in done_o cycle accepted.
